// File: rtl/flt_pkg.sv
// Shared definitions for the fltflt job dispatcher.
//   - FSM state codes (plain 3-bit constants so older netlists and
//     waveform scripts keep the same encodings)
//   - byte offsets of the operands and the result inside the processor's
//     data-memory window, relative to BASE_ADDR
//   - fp16 field layout
//   - wr_byte(): picks the byte that goes out on each write cycle
package flt_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RD_HI  = 3'd4;
  localparam logic [2:0] S_RD_LO  = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;
  localparam logic [2:0] S_OUT    = 3'd7;

  localparam logic [7:0] OFS_F1_HI  = 8'd0;
  localparam logic [7:0] OFS_F1_LO  = 8'd1;
  localparam logic [7:0] OFS_F2_HI  = 8'd2;
  localparam logic [7:0] OFS_F2_LO  = 8'd3;
  localparam logic [7:0] OFS_RES_HI = 8'd4;
  localparam logic [7:0] OFS_RES_LO = 8'd5;

  localparam int FP16_SIGN_W = 1;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS   = 15;

  typedef struct packed {
    logic [FP16_SIGN_W-1:0] sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_t;

  // Write order is MSB byte first: flt1 hi, flt1 lo, flt2 hi, flt2 lo.
  function automatic logic [7:0] wr_byte(input fp16_t f1, input fp16_t f2,
                                         input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = f1[15:8];
      2'd1:    b = f1[7:0];
      2'd2:    b = f2[15:8];
      default: b = f2[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flt_dispatch_timer.sv
// Launch-to-done cycle counter with timeout detection.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (count -> 0)
//   clr          - zero the counter (asserted in the launch cycle)
//   en           - count this cycle (asserted in every wait cycle)
//   count        - wait cycles elapsed so far, saturating at all-ones
//   expired      - the cycle being counted now is the TIMEOUT_CYC-th one
module flt_dispatch_timer #(
  parameter int CYC_W       = 16,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the cycles already finished, so the current cycle is
  // number count+1; flagging it here lets the FSM leave on exactly the
  // TIMEOUT_CYC-th wait cycle while the counter lands on TIMEOUT_CYC.
  assign expired = en && (32'(count) >= 32'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/flt_job_dispatcher.sv
// Upstream feeder for the fltflt half-precision add processor.
// Takes an fp16 operand pair, writes it into the processor's data memory
// at BASE_ADDR..+3 (MSB byte first), releases cpu_start, waits for
// cpu_done (or a timeout), reads the sum from BASE_ADDR+4/+5, halts the
// processor again and presents sum, cycle count and timeout flag.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   in_valid/in_ready       - operand stream handshake
//   in_flt1, in_flt2        - fp16 operands
//   mem_addr/mem_wdata/mem_we - data-memory port (byte wide)
//   mem_rdata               - combinational read data for mem_addr
//   cpu_start               - 1 holds the processor, 0 lets it run
//   cpu_done                - processor finished
//   out_valid/out_ready     - result stream handshake
//   out_flt3                - fp16 sum (0 on timeout)
//   out_timeout             - job aborted
//   out_cycles              - wait cycles from launch to done, saturating
//   busy                    - a job is in flight
module flt_job_dispatcher
  import flt_pkg::*;
#(
  parameter int BASE_ADDR   = 128,
  parameter int TIMEOUT_CYC = 25000,
  parameter int CYC_W       = 16,
  parameter int START_HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_flt1,
  input  logic [15:0]      in_flt2,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             mem_we,
  input  logic [7:0]       mem_rdata,
  output logic             cpu_start,
  input  logic             cpu_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_flt3,
  output logic             out_timeout,
  output logic [CYC_W-1:0] out_cycles,
  output logic             busy
);

  localparam logic [7:0]  BASE     = 8'(BASE_ADDR);
  localparam logic [15:0] HOLD_END = 16'(START_HOLD - 1);

  logic [2:0]  state;
  logic [15:0] step;
  fp16_t       op1;
  fp16_t       op2;
  logic        accept;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_expired;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign mem_we    = (state == S_WR);
  assign cpu_start = !((state == S_LAUNCH) || (state == S_WAIT));
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign timer_clr = (state == S_LAUNCH);
  assign timer_en  = (state == S_WAIT);

  flt_dispatch_timer #(
    .CYC_W       (CYC_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .count   (out_cycles),
    .expired (timer_expired)
  );

  // Operands are pure data: captured on accept, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1 <= fp16_t'(in_flt1);
      op2 <= fp16_t'(in_flt2);
    end
  end

  // mem_addr/mem_wdata are registers loaded one cycle ahead of the state
  // that uses them, so they hold their last value whenever unused and the
  // memory sees a glitch-free address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      step        <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      out_flt3    <= '0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_WR;
            step      <= '0;
            mem_addr  <= BASE + OFS_F1_HI;
            mem_wdata <= in_flt1[15:8];
          end
        end
        // ---- write phase: four bytes on consecutive cycles ----
        S_WR: begin
          if (step[1:0] == 2'd3) begin
            state <= S_LAUNCH;
          end else begin
            step      <= step + 16'd1;
            mem_addr  <= BASE + {6'd0, step[1:0] + 2'd1};
            mem_wdata <= wr_byte(op1, op2, step[1:0] + 2'd1);
          end
        end
        // ---- launch: one cycle, a leftover done from the last job is ignored ----
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        // ---- wait: done has priority over a simultaneous timeout ----
        S_WAIT: begin
          if (cpu_done) begin
            state    <= S_RD_HI;
            mem_addr <= BASE + OFS_RES_HI;
          end else if (timer_expired) begin
            state       <= S_HOLD;
            step        <= '0;
            out_flt3    <= '0;
            out_timeout <= 1'b1;
          end
        end
        // ---- read phase ----
        S_RD_HI: begin
          out_flt3[15:8] <= mem_rdata;
          mem_addr       <= BASE + OFS_RES_LO;
          state          <= S_RD_LO;
        end
        S_RD_LO: begin
          out_flt3[7:0] <= mem_rdata;
          step          <= '0;
          state         <= S_HOLD;
        end
        // ---- hold: keep the processor halted before the next launch ----
        S_HOLD: begin
          if (step == HOLD_END) begin
            state <= S_OUT;
          end else begin
            step <= step + 16'd1;
          end
        end
        // ---- output: hold results until the consumer takes them ----
        default: begin
          if (out_ready) begin
            state       <= S_IDLE;
            out_timeout <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flt_job_dispatcher.sv
module tb_flt_job_dispatcher;

  localparam int TO   = 50;
  localparam int SH   = 2;
  localparam int BASE = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_flt1 = 16'h0;
  logic [15:0] in_flt2 = 16'h0;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        cpu_start;
  logic        cpu_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_flt3;
  logic        out_timeout;
  logic [15:0] out_cycles;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // memory / mock processor state
  logic [7:0] mem [256];
  logic [7:0] res_hi = 8'h00;
  logic [7:0] res_lo = 8'h00;
  int         cyc = 0;
  int         lowcnt = 0;
  int         last_low_run = 0;
  int         done_delay = 0;
  bit         stale_mode = 1'b0;

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wr_log[$];

  flt_job_dispatcher #(
    .BASE_ADDR   (BASE),
    .TIMEOUT_CYC (TO),
    .CYC_W       (16),
    .START_HOLD  (SH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_flt1     (in_flt1),
    .in_flt2     (in_flt2),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .cpu_start   (cpu_start),
    .cpu_done    (cpu_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_flt3    (out_flt3),
    .out_timeout (out_timeout),
    .out_cycles  (out_cycles),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // The processor deposits its result at BASE+4/+5; everything else is RAM.
  assign mem_rdata = (mem_addr == 8'(BASE + 4)) ? res_hi :
                     (mem_addr == 8'(BASE + 5)) ? res_lo : mem[mem_addr];

  // lowcnt = cycles cpu_start has been low, including the current one.
  // The real done arrives done_delay cycles after start falls; in stale
  // mode a spurious done also shows up in the very first low cycle.
  assign cpu_done = (stale_mode && (lowcnt == 1)) ||
                    ((done_delay != 0) && (lowcnt >= done_delay + 1));

  always @(negedge clk) begin
    if (cpu_start === 1'b0) begin
      lowcnt <= lowcnt + 1;
    end else begin
      lowcnt <= 0;
      if (lowcnt != 0) last_low_run <= lowcnt;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wr_log.push_back('{c: cyc, a: mem_addr, d: mem_wdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string name, input logic [15:0] f1, input logic [15:0] f2,
                         input logic [15:0] res, input int delay, input bit stale, input int bp);
    bit          ok;
    bit          tmo;
    bit          stable;
    logic [15:0] exp3;
    int          expc;
    int          base_idx;
    logic [15:0] h3;
    logic [15:0] hc;
    logic [7:0]  exp_bytes [4];

    // reference: the sum is whatever the processor left, unless no done
    // came within TO wait cycles (a done on cycle TO still counts)
    tmo  = (delay == 0) || (delay > TO);
    exp3 = tmo ? 16'h0000 : res;
    expc = tmo ? TO : delay;
    exp_bytes[0] = f1[15:8];
    exp_bytes[1] = f1[7:0];
    exp_bytes[2] = f2[15:8];
    exp_bytes[3] = f2[7:0];

    res_hi     = res[15:8];
    res_lo     = res[7:0];
    done_delay = delay;
    stale_mode = stale;
    base_idx   = wr_log.size();

    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, ":ready_wait"}, 32'(ok), 32'd1);

    in_valid = 1'b1;
    in_flt1  = f1;
    in_flt2  = f2;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ":busy_after_accept"}, 32'({busy, in_ready}), 32'b10);

    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, ":out_valid_wait"}, 32'(ok), 32'd1);
    check({name, ":flt3"}, 32'(out_flt3), 32'(exp3));
    check({name, ":cycles"}, 32'(out_cycles), 32'(expc));
    check({name, ":timeout"}, 32'(out_timeout), 32'(tmo));
    check({name, ":start_ready_at_out"}, 32'({cpu_start, in_ready}), 32'b10);

    stable = 1'b1;
    h3 = out_flt3;
    hc = out_cycles;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_flt3 !== h3 || out_cycles !== hc ||
          in_ready !== 1'b0 || cpu_start !== 1'b1)
        stable = 1'b0;
    end
    if (bp > 0) check({name, ":backpressure_stable"}, 32'(stable), 32'd1);

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ":after_handshake"}, 32'({out_valid, in_ready, busy, out_timeout}), 32'b0100);

    // start is low for the launch cycle plus every wait cycle
    check({name, ":start_low_run"}, 32'(last_low_run), 32'(expc + 1));

    check({name, ":write_count"}, 32'(wr_log.size() - base_idx), 32'd4);
    if (wr_log.size() - base_idx == 4) begin
      for (int i = 0; i < 4; i++) begin
        check({name, ":write_addr_data"}, 32'({wr_log[base_idx+i].a, wr_log[base_idx+i].d}),
              32'({8'(BASE + i), exp_bytes[i]}));
        check({name, ":write_cycle"}, 32'(wr_log[base_idx+i].c - wr_log[base_idx].c), 32'(i));
      end
    end
  endtask

  initial begin
    logic [15:0] f1;
    logic [15:0] f2;

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst:cpu_start", 32'(cpu_start), 32'd1);
    check("rst:mem_we", 32'(mem_we), 32'd0);
    check("rst:mem_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd0);
    check("rst:out_valid_busy", 32'({out_valid, busy}), 32'd0);
    check("rst:out_fields", 32'({out_flt3, out_timeout}), 32'd0);
    check("rst:out_cycles", 32'(out_cycles), 32'd0);
    reset = 1'b0;
    #1;
    check("rst:in_ready_release", 32'(in_ready), 32'd1);

    // directed jobs
    run_job("basic", 16'h1A04, 16'h1A04, 16'h1E04, 37, 1'b0, 0);
    run_job("timeout", 16'h3C00, 16'h4000, 16'hBEEF, 0, 1'b0, 0);
    run_job("backpressure", 16'h4500, 16'hC100, 16'h4300, 20, 1'b0, 10);
    run_job("stale_done", 16'h0001, 16'h8001, 16'h0000, 5, 1'b1, 0);
    run_job("done_at_limit", 16'h7BFF, 16'h0400, 16'h7C00, TO, 1'b0, 1);
    run_job("one_past_limit", 16'h1234, 16'h5678, 16'h9ABC, TO + 1, 1'b0, 0);
    run_job("done_first_cycle", 16'hFFFF, 16'h0000, 16'hA5A5, 1, 1'b0, 0);

    // reset in the middle of a wait
    res_hi     = 8'h11;
    res_lo     = 8'h22;
    done_delay = 0;
    stale_mode = 1'b0;
    in_valid   = 1'b1;
    in_flt1    = 16'hDEAD;
    in_flt2    = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_wait:running", 32'(cpu_start), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_wait:in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_wait:halted", 32'({cpu_start, mem_we, out_valid, busy}), 32'b1000);
    check("rst_wait:out_cleared", 32'({out_flt3, out_cycles}), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_wait:in_ready_release", 32'(in_ready), 32'd1);
    run_job("after_reset", 16'h4A10, 16'h4204, 16'h4C0A, 12, 1'b0, 0);

    // randomized jobs, delays spanning both sides of the timeout
    for (int k = 0; k < 8; k++) begin
      f1 = 16'($urandom);
      f2 = 16'($urandom);
      run_job("random", f1, f2, 16'($urandom), int'($urandom_range(1, 60)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flt_job_dispatcher.md
Name: flt_job_dispatcher

Overview:
- Upstream feeder for the fltflt half-precision add processor.
- Accepts fp16 operand pairs on a valid/ready stream and writes them into the processor's data memory at BASE_ADDR..BASE_ADDR+3, MSB byte first.
- Launches the processor by releasing start, then waits for done.
- Reads the result from BASE_ADDR+4/+5, re-halts the processor and emits the sum, a cycle count and a timeout flag on an output stream.

Parameters:
- BASE_ADDR, 128: data-memory byte address of flt1 MSB. Offsets: +0/+1 flt1, +2/+3 flt2, +4/+5 result.
- TIMEOUT_CYC, 25000: maximum wait cycles for cpu_done before aborting.
- CYC_W, 16: width of the cycle counter and out_cycles.
- START_HOLD, 2: minimum cycles cpu_start stays high after a job, before the next launch.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  dispatcher can accept a pair
- in_flt1  in  16  fp16 operand 1
- in_flt2  in  16  fp16 operand 2
- mem_addr  out  8  data-memory byte address
- mem_wdata  out  8  write data
- mem_we  out  1  write enable
- mem_rdata  in  8  read data, combinational from mem_addr
- cpu_start  out  1  high = processor held; falling = run
- cpu_done  in  1  processor finished
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_flt3  out  16  fp16 sum
- out_timeout  out  1  job aborted; out_flt3 = 16'h0000
- out_cycles  out  CYC_W  cycles from launch to done, saturating
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is synchronous and active-high. It forces state IDLE in the next cycle from any state.
- Reset values: cpu_start=1, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0 during the reset cycle, out_valid=0, out_flt3=0, out_timeout=0, out_cycles=0, busy=0.
- cpu_start is 1 in every state except LAUNCH and WAIT. The processor is therefore halted whenever memory is being written or read.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch both operands and go to WR.
- State WR (4 cycles, index 0..3):
  - mem_we=1 every cycle.
  - mem_addr=BASE_ADDR+index.
  - mem_wdata = flt1[15:8], flt1[7:0], flt2[15:8], flt2[7:0] in that order.
  - After index 3, go to LAUNCH.
- State LAUNCH (1 cycle):
  - cpu_start=0, counter cleared.
  - cpu_done is ignored in this cycle (it may be stale from the prior job).
- State WAIT:
  - cpu_start=0; counter increments every cycle, saturating at 2^CYC_W-1.
  - cpu_done=1 → RD_HI.
  - Counter reaching TIMEOUT_CYC with no done → set timeout, out_flt3=0, go to HOLD.
  - If done and the timeout fall on the same cycle, done wins.
- State RD_HI: mem_addr=BASE_ADDR+4; capture mem_rdata into flt3[15:8].
- State RD_LO: mem_addr=BASE_ADDR+5; capture mem_rdata into flt3[7:0].
- State HOLD: cpu_start=1 for START_HOLD cycles, then go to OUT.
- State OUT:
  - out_valid=1, with outputs stable until out_ready.
  - On the handshake cycle: out_valid drops next cycle, out_timeout clears, state returns to IDLE.
- in_ready is 0 in every non-IDLE state. There is no overlap between jobs.
- Latency with immediate out_ready, counted from the accept cycle to the out_valid cycle: 4 + 1 + N + 2 + START_HOLD, where N = WAIT cycles including the done cycle. out_cycles = N.
- mem_we is never high outside WR.
- mem_addr holds its last value when unused; it is don't-care outside WR and RD.
- Reset during WR aborts the partial write; a reasserted cpu_start halts the processor.

Decomposition:
- Package flt_pkg:
  - state enum {IDLE, WR, LAUNCH, WAIT, RD_HI, RD_LO, HOLD, OUT}
  - address offsets OFS_F1_HI..OFS_RES_LO (0..5)
  - fp16 field widths: SIGN=1, EXP=5, MANT=10, BIAS=15
- One sub-module, flt_dispatch_timer: saturating launch-to-done counter plus timeout compare. Interface: clr, en, count, expired.

Test Plan:
- Basic job:
  - Stimulus: flt1=16'h1A04, flt2=16'h1A04; mock CPU raises done 37 cycles after start falls; mem[132]=8'h1E, mem[133]=8'h04.
  - Required: writes 128←1A, 129←04, 130←1A, 131←04 on consecutive cycles; out_flt3=16'h1E04, out_cycles=37, out_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT_CYC=50, done never asserts.
  - Required: out_valid after 50 WAIT cycles, out_timeout=1, out_flt3=0, cpu_start=1 from HOLD onward.
- Backpressure:
  - Stimulus: out_ready held low for 10 cycles after out_valid.
  - Required: out_flt3/out_cycles stable, in_ready=0 throughout; IDLE one cycle after the handshake.
- Stale done:
  - Stimulus: cpu_done high only in the LAUNCH cycle, then low; real done arrives 5 cycles later.
  - Required: completion taken at the real done, out_cycles=5.
- Reset in WAIT:
  - Stimulus: reset pulsed for 1 cycle mid-WAIT.
  - Required: next cycle cpu_start=1, mem_we=0, out_valid=0, in_ready=1 after release; a following job with flt1=16'h4A10, flt2=16'h4204 completes normally.
